// File: rtl/word_framer_pkg.sv
// word_framer_pkg: shared types and helpers for the word framer.
//   state_t         - framer FSM states (COLLECT, CAPTURE)
//   bytes_per_word  - number of shifted-in bytes that make one assembled word
package word_framer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  function automatic int unsigned bytes_per_word(input int unsigned din_width,
                                                 input int unsigned dout_width);
    return dout_width / din_width;
  endfunction

endpackage

// File: rtl/word_framer_fifo.sv
// word_framer_fifo: synchronous first-word-fall-through FIFO, DEPTH x WIDTH.
// The head word sits in an output register that is refilled from the storage
// array, so a push into an empty FIFO shows up on the head one cycle after the
// write (no bypass). Occupancy counts the array plus the head register.
// Ports:
//   clk, rst     - clock, async active-high reset
//   clr          - synchronous clear (pointers, occupancy, head)
//   push/wr_data - write request and word; refused when full unless popping
//   pop          - consume head (ignored while empty)
//   rd_data      - head word, held while not popped
//   full, empty  - registered status; empty is low exactly when the head is valid
module word_framer_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    occ;
  logic [PW-1:0]    occ_next_c;
  logic             head_valid;
  logic             do_pop_c;
  logic             do_push_c;
  logic             load_c;

  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign do_pop_c   = pop && head_valid;
  assign do_push_c  = push && (!full || do_pop_c);
  // Refill the head from the array; uses pre-write pointers so there is no bypass.
  assign load_c     = (wr_ptr != rd_ptr) && (!head_valid || do_pop_c);
  assign occ_next_c = occ + PW'(do_push_c) - PW'(do_pop_c);
  assign empty      = !head_valid;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointers wrap modulo DEPTH; the extra MSB separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      full       <= 1'b0;
      head_valid <= 1'b0;
      rd_data    <= '0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      full       <= 1'b0;
      head_valid <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (do_push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (load_c) begin
        rd_ptr     <= rd_ptr + PW'(1);
        rd_data    <= mem[rd_ptr[AW-1:0]];
        head_valid <= 1'b1;
      end else if (do_pop_c) begin
        head_valid <= 1'b0;
      end
      occ  <= occ_next_c;
      full <= (occ_next_c == PW'(DEPTH));
    end
  end

endmodule

// File: rtl/word_framer.sv
// word_framer: counts shift strobes of an upstream byte shift register and,
// once a full word has been shifted in, captures the shift-register output
// into an output FIFO with a valid/ready interface.
// Optional feature macro: WORD_FRAMER_TIMEOUT_EN - discard a partial word
// after TIMEOUT idle cycles and flag it on the sticky resync output.
// Ports:
//   clk, rst          - clock, async active-high reset
//   sclr              - sync clear of count, FIFO, state and sticky flags
//   shift             - byte strobe (same pulse that advances the shift register)
//   word_in           - shift-register output, valid the cycle after a shift
//   m_valid/m_data    - FIFO head
//   m_ready           - consumer accept
//   byte_cnt          - bytes received toward the current word
//   overflow          - sticky: a completed word was dropped on a full FIFO
//   resync            - sticky: a partial word was discarded by timeout
module word_framer
  import word_framer_pkg::*;
#(
  parameter int unsigned DIN_WIDTH  = 8,
  parameter int unsigned DOUT_WIDTH = 24,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclr,
  input  logic                  shift,
  input  logic [DOUT_WIDTH-1:0] word_in,
  output logic                  m_valid,
  output logic [DOUT_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [$clog2(bytes_per_word(DIN_WIDTH, DOUT_WIDTH)):0] byte_cnt,
  output logic                  overflow,
  output logic                  resync
);

  localparam int unsigned N  = bytes_per_word(DIN_WIDTH, DOUT_WIDTH);
  localparam int unsigned CW = $clog2(N) + 1;

  // Elaboration-time parameter sanity check.
  if (((DOUT_WIDTH % DIN_WIDTH) != 0) || (N < 2) || (DEPTH < 2) ||
      ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
    $error("word_framer: illegal parameter set");
  end

  state_t state;
  logic   push_c;
  logic   pop_c;
  logic   full;
  logic   empty;

  // The shift register output holds the complete word during CAPTURE.
  assign push_c  = (state == CAPTURE) && !sclr;
  assign pop_c   = m_valid && m_ready && !sclr;
  assign m_valid = !empty;

  word_framer_fifo #(
    .WIDTH (DOUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (sclr),
    .push    (push_c),
    .wr_data (word_in),
    .pop     (pop_c),
    .rd_data (m_data),
    .full    (full),
    .empty   (empty)
  );

`ifdef WORD_FRAMER_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] idle_cnt;
  logic          idle_hit_c;

  assign idle_hit_c = (state == COLLECT) && !shift && (byte_cnt != '0) &&
                      (idle_cnt == IW'(TIMEOUT - 1));

  // Idle counter runs only while a partial word is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      resync   <= 1'b0;
    end else if (sclr) begin
      idle_cnt <= '0;
      resync   <= 1'b0;
    end else if (shift || (byte_cnt == '0)) begin
      idle_cnt <= '0;
    end else if (idle_hit_c) begin
      idle_cnt <= '0;
      resync   <= 1'b1;
    end else begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end
`else
  assign resync = 1'b0;
`endif

  // Framing FSM, byte counter and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= COLLECT;
      byte_cnt <= '0;
      overflow <= 1'b0;
    end else if (sclr) begin
      state    <= COLLECT;
      byte_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (shift) begin
            if (byte_cnt == CW'(N - 1)) begin
              byte_cnt <= '0;
              state    <= CAPTURE;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
            end
          end
`ifdef WORD_FRAMER_TIMEOUT_EN
          else if (idle_hit_c) begin
            byte_cnt <= '0;
          end
`endif
        end
        CAPTURE: begin
          // A shift here is the first byte of the next word.
          state <= COLLECT;
          if (shift) begin
            byte_cnt <= CW'(1);
          end
        end
      endcase
      if (push_c && full && !pop_c) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
